async_hs_tx: RTL and testbench
==============================

# async_hs_tx

Clocked four-phase bundled-data transmitter that launches words from the synchronous domain into the Muller C-element (self-timed) pipeline. It accepts words on a valid/ready interface, buffers them in a 2-entry FIFO, and for each word drives data plus req. It holds data for a configurable setup time before raising req, which enforces the bundling constraint. It then completes the return-to-zero handshake against the asynchronous ack coming back from the first C-element stage.

## Interface
Parameters:
- WIDTH, 8: bundled data width.
- SETUP_CYC, 2: clock cycles data_o is stable before req_o rises; legal range 1..15.
- SYNC_STAGES, 2: flops in the ack_i synchronizer; minimum 2.
- TIMEOUT, 0: handshake timeout in cycles per phase; 0 disables the check.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- s_valid  in  1  producer word valid.
- s_ready  out  1  FIFO can accept a word.
- s_data  in  WIDTH  producer word.
- req_o  out  1  four-phase request to the C-element pipeline.
- data_o  out  WIDTH  bundled data.
- ack_i  in  1  asynchronous acknowledge from the pipeline.
- busy  out  1  FSM not in IDLE, or FIFO non-empty.
- tx_count  out  16  completed handshakes; wraps.
- timeout_err  out  1  sticky handshake-timeout flag.

## Operation
- FIFO: 2 entries, registered occupancy.
  - s_ready = (occupancy < 2).
  - Push on s_valid && s_ready.
  - Pop when the FSM loads data_o.
  - Push and pop in the same cycle leave occupancy unchanged.
- ack_s: ack_i passed through SYNC_STAGES flops, all reset to 0. The FSM uses only ack_s.
- FSM states: IDLE, SETUP, REQ_HI, REQ_LO.
  - IDLE: if FIFO non-empty and ack_s==0, load data_o <= FIFO head, pop, set setup counter = SETUP_CYC-1, go to SETUP. If ack_s==1 in IDLE (protocol violation), wait.
  - SETUP: decrement the counter. When the counter reaches 0, set req_o <= 1 and go to REQ_HI.
  - REQ_HI: when ack_s==1, set req_o <= 0 and go to REQ_LO.
  - REQ_LO: when ack_s==0, set tx_count <= tx_count+1 and go to IDLE.
- data_o is held constant from its load until the FSM returns to IDLE. data_o is never changed while req_o or ack_s is high.
- Timeout (TIMEOUT>0):
  - A phase counter clears on entry to REQ_HI and on entry to REQ_LO, and increments every cycle in those states.
  - Reaching TIMEOUT sets timeout_err. The FSM keeps waiting and is not aborted.
  - timeout_err clears only on rst.
- tx_count wraps from 16'hFFFF to 0.

## Timing
- Reset values: s_ready=0 while rst is high and 1 on the first cycle after release. req_o=0, data_o=0, busy=0, tx_count=0, timeout_err=0. FSM=IDLE, FIFO empty.
- Latency, SETUP_CYC=2, FIFO empty, ack_s=0:
  - Word accepted at edge N.
  - data_o updates at edge N+1.
  - req_o rises at edge N+1+SETUP_CYC (N+3).
- ack synchronization: an ack_i edge is seen by the FSM SYNC_STAGES edges after it is first sampled. req_o falls on the edge where ack_s is first 1.
- Back-to-back words: minimum word period = 1 (IDLE) + SETUP_CYC + ack round trip + 2×SYNC_STAGES cycles. The FIFO absorbs 2 words during this period. s_ready drops the cycle after the second unpopped push.
- Reset mid-handshake:
  - req_o, data_o, FIFO, synchronizer and counters clear asynchronously.
  - On release the FSM is IDLE and must not launch until ack_s==0. This covers a pipeline that still holds ack high.
- tx_count increments exactly once per completed four-phase cycle, on the REQ_LO to IDLE edge.

## Test plan
- Single word, SETUP_CYC=2: push 8'hA5 at edge N; an ack model responds 3 cycles after req.
  - Required: data_o=A5 at N+1, req_o=1 at N+3, req_o falls 2 edges after ack_i rises, tx_count=1.
- Burst of 4 words (11, 22, 33, 44) with s_valid held high.
  - Required: s_ready deasserts when the FIFO is full, all 4 words emerge in order on data_o, tx_count=4.
  - Required: data_o never changes while req_o or ack_s is high.
- ack_i stuck at 0, TIMEOUT=16.
  - Required: timeout_err=1 after 16 cycles in REQ_HI and stays set.
  - Then raise ack_i: the handshake completes and tx_count increments.
- Assert rst while in REQ_HI with ack_i high.
  - Required: req_o=0 and data_o=0 immediately, without waiting for a clock edge.
  - After release with ack_i still high and one word pushed: no launch until ack_i has been low for SYNC_STAGES edges.
- Preload tx_count to 16'hFFFF by running 65535 transfers, then run one more.
  - Required: tx_count=0, with no other side effects.
- Push 16'h0 and 16'hFFFF with WIDTH=16.
  - Required: both emerge unchanged.

Source files
------------

// File: rtl/async_hs_tx.sv
// Clocked four-phase bundled-data transmitter feeding a self-timed C-element pipeline.
// Words pass through a 2-entry FIFO and are launched with a setup delay before req_o.
module async_hs_tx #(
  parameter int WIDTH       = 8,
  parameter int SETUP_CYC   = 2,
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT     = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [WIDTH-1:0] s_data,
  output logic             req_o,
  output logic [WIDTH-1:0] data_o,
  input  logic             ack_i,
  output logic             busy,
  output logic [15:0]      tx_count,
  output logic             timeout_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    REQ_HI = 2'd2,
    REQ_LO = 2'd3
  } state_t;

  localparam int          WARM_W     = $clog2(SYNC_STAGES + 1);
  localparam logic [3:0]  SETUP_INIT = 4'(SETUP_CYC - 1);
  localparam logic [15:0] TO_LIM     = 16'(TIMEOUT);
  localparam logic        TO_EN      = (TIMEOUT != 0);

  logic [WIDTH-1:0]       fifo_mem_r [2];
  logic                   wr_ptr_r, rd_ptr_r;
  logic [1:0]             occ_r, occ_s;
  logic                   push_s, pop_s;
  logic                   s_ready_r;

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   ack_s;
  logic [WARM_W-1:0]      warm_r;
  logic                   warm_done_s;

  state_t                 state_r, state_s;
  logic [3:0]             setup_r, setup_s;
  logic                   req_r, req_s;
  logic [WIDTH-1:0]       data_r, data_s;
  logic [15:0]            tx_cnt_r, tx_s;
  logic [15:0]            phase_r, phase_s, phase_inc_s;
  logic                   hit_s;
  logic                   err_r, err_s;
  logic                   busy_r, busy_s;

  assign s_ready     = s_ready_r;
  assign req_o       = req_r;
  assign data_o      = data_r;
  assign busy        = busy_r;
  assign tx_count    = tx_cnt_r;
  assign timeout_err = err_r;

  assign push_s      = s_valid & s_ready_r;
  assign ack_s       = sync_r[SYNC_STAGES-1];
  // After reset the synchronizer holds 0 regardless of ack_i, so launches wait until it has refilled.
  assign warm_done_s = (warm_r == WARM_W'(SYNC_STAGES));
  assign phase_inc_s = (phase_r == TO_LIM) ? phase_r : (phase_r + 16'd1);
  assign hit_s       = TO_EN & (phase_inc_s == TO_LIM);

  // FIFO occupancy next-state
  always_comb begin
    occ_s = occ_r;
    case ({push_s, pop_s})
      2'b10:   occ_s = occ_r + 2'd1;
      2'b01:   occ_s = occ_r - 2'd1;
      default: occ_s = occ_r;
    endcase
  end

  // Handshake FSM next-state and register next values
  always_comb begin
    state_s = state_r;
    setup_s = setup_r;
    req_s   = req_r;
    data_s  = data_r;
    tx_s    = tx_cnt_r;
    phase_s = phase_r;
    err_s   = err_r;
    pop_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if ((occ_r != 2'd0) && !ack_s && warm_done_s) begin
          data_s  = fifo_mem_r[rd_ptr_r];
          pop_s   = 1'b1;
          setup_s = SETUP_INIT;
          state_s = SETUP;
        end else begin
          state_s = IDLE;
        end
      end
      SETUP: begin
        if (setup_r == 4'd0) begin
          req_s   = 1'b1;
          phase_s = 16'd0;
          state_s = REQ_HI;
        end else begin
          setup_s = setup_r - 4'd1;
        end
      end
      REQ_HI: begin
        if (ack_s) begin
          req_s   = 1'b0;
          phase_s = 16'd0;
          state_s = REQ_LO;
        end else begin
          phase_s = phase_inc_s;
          err_s   = err_r | hit_s;
        end
      end
      REQ_LO: begin
        if (!ack_s) begin
          tx_s    = tx_cnt_r + 16'd1;
          state_s = IDLE;
        end else begin
          phase_s = phase_inc_s;
          err_s   = err_r | hit_s;
        end
      end
      default: begin
        req_s   = 1'b0;
        state_s = IDLE;
      end
    endcase
  end

  assign busy_s = (state_s != IDLE) || (occ_s != 2'd0);

  // FIFO storage, pointers and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fifo_mem_r[0] <= {WIDTH{1'b0}};
      fifo_mem_r[1] <= {WIDTH{1'b0}};
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      occ_r         <= 2'd0;
      s_ready_r     <= 1'b0;
    end else begin
      if (push_s) begin
        fifo_mem_r[wr_ptr_r] <= s_data;
      end
      wr_ptr_r  <= wr_ptr_r ^ push_s;
      rd_ptr_r  <= rd_ptr_r ^ pop_s;
      occ_r     <= occ_s;
      s_ready_r <= (occ_s < 2'd2);
    end
  end

  // ack_i synchronizer and post-reset warm-up counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      warm_r <= {WARM_W{1'b0}};
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], ack_i};
      if (!warm_done_s) begin
        warm_r <= warm_r + WARM_W'(1);
      end
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      setup_r  <= 4'd0;
      req_r    <= 1'b0;
      data_r   <= {WIDTH{1'b0}};
      tx_cnt_r <= 16'd0;
      phase_r  <= 16'd0;
      err_r    <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      setup_r  <= setup_s;
      req_r    <= req_s;
      data_r   <= data_s;
      tx_cnt_r <= tx_s;
      phase_r  <= phase_s;
      err_r    <= err_s;
      busy_r   <= busy_s;
    end
  end

endmodule

// File: tb/tb_async_hs_tx.sv
// Directed bench for async_hs_tx: scoreboard of launched words, ack responder model,
// latency, burst, timeout, async reset, counter wrap and data extremes.
module tb_async_hs_tx;
  localparam int W  = 16;
  localparam int SC = 2;
  localparam int SS = 2;
  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         s_valid = 1'b0;
  logic         s_ready;
  logic [W-1:0] s_data = 16'h0000;
  logic         req_o;
  logic [W-1:0] data_o;
  logic         ack_i = 1'b0;
  logic         busy;
  logic [15:0]  tx_count;
  logic         timeout_err;

  async_hs_tx #(.WIDTH(W), .SETUP_CYC(SC), .SYNC_STAGES(SS), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .req_o(req_o), .data_o(data_o), .ack_i(ack_i), .busy(busy),
    .tx_count(tx_count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad = 0;
  int           exp_tx = 0;
  logic [W-1:0] exp_q [$];
  bit           auto_ack = 1'b0;
  bit           ack_force = 1'b0;
  int           ack_dly = 3;
  int           ack_wait = 0;
  bit           saw_full = 1'b0;
  logic         prev_req = 1'b0;
  logic [W-1:0] prev_data = 16'h0000;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pipeline ack model: follows req_o after ack_dly negedges, or holds a forced level
  always @(negedge clk) begin
    if (!auto_ack) begin
      ack_i = ack_force;
      ack_wait = 0;
    end else if (req_o != ack_i) begin
      ack_wait++;
      if (ack_wait >= ack_dly) begin
        ack_i = req_o;
        ack_wait = 0;
      end
    end else begin
      ack_wait = 0;
    end
  end

  // Scoreboard pop on each req_o rise, plus bundling stability check
  always @(negedge clk) begin
    if (!rst) begin
      if (req_o || dut.ack_s) chk("data_stable", data_o, prev_data);
      if (req_o && !prev_req) begin
        if (exp_q.size() == 0) chk("unexpected_launch", 32'd1, 32'd0);
        else chk("data_order", data_o, exp_q.pop_front());
      end
    end
    prev_req  <= req_o;
    prev_data <= data_o;
  end

  task automatic push(input logic [W-1:0] d);
    int n = 0;
    s_data  = d;
    s_valid = 1'b1;
    while (s_ready !== 1'b1 && n < 200) begin
      saw_full = 1'b1;
      @(negedge clk);
      n++;
    end
    if (n >= 200) chk("push_timeout", 32'(n), 32'd0);
    exp_q.push_back(d);
    @(negedge clk);
  endtask

  task automatic wait_req(input logic v, input string tag);
    int n = 0;
    while (req_o !== v && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) chk(tag, 32'(req_o), 32'(v));
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2000) chk("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic set_ack(input bit v);
    #1 ack_force = v;
    @(negedge clk);
  endtask

  initial begin
    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_s_ready", 32'(s_ready), 32'd0);
    chk("rst_req", 32'(req_o), 32'd0);
    chk("rst_data", 32'(data_o), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_tx", 32'(tx_count), 32'd0);
    chk("rst_err", 32'(timeout_err), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", 32'(s_ready), 32'd1);
    repeat (2) @(negedge clk);

    // Single word latency and ack-to-req-fall timing
    auto_ack = 1'b1;
    ack_dly  = 3;
    s_data   = 16'h00A5;
    s_valid  = 1'b1;
    exp_q.push_back(16'h00A5);
    @(negedge clk);
    s_valid = 1'b0;
    @(negedge clk);
    chk("lat_data_n1", 32'(data_o), 32'h00A5);
    chk("lat_req_n1", 32'(req_o), 32'd0);
    @(negedge clk);
    chk("lat_req_n2", 32'(req_o), 32'd0);
    @(negedge clk);
    chk("lat_req_n3", 32'(req_o), 32'd1);
    begin
      int n = 0;
      while (ack_i !== 1'b1 && n < 50) begin
        @(posedge clk);
        n++;
      end
      if (n >= 50) chk("ack_rise_timeout", 32'(ack_i), 32'd1);
    end
    #1 chk("req_hold_after_ack", 32'(req_o), 32'd1);
    @(posedge clk);
    @(posedge clk);
    #1 chk("req_fall_after_sync", 32'(req_o), 32'd0);
    wait_idle();
    exp_tx = 1;
    chk("tx_single", 32'(tx_count), 32'(exp_tx));

    // Burst of four with s_valid held high
    @(negedge clk);
    saw_full = 1'b0;
    push(16'h0011);
    push(16'h0022);
    push(16'h0033);
    push(16'h0044);
    s_valid = 1'b0;
    chk("burst_fifo_full", 32'(saw_full), 32'd1);
    wait_idle();
    exp_tx += 4;
    chk("tx_burst", 32'(tx_count), 32'(exp_tx));

    // Timeout with ack stuck low, then late completion
    auto_ack = 1'b0;
    set_ack(1'b0);
    push(16'h1234);
    s_valid = 1'b0;
    wait_req(1'b1, "to_req_rise");
    repeat (14) @(negedge clk);
    chk("to_not_yet", 32'(timeout_err), 32'd0);
    repeat (2) @(negedge clk);
    chk("to_set", 32'(timeout_err), 32'd1);
    repeat (10) @(negedge clk);
    chk("to_sticky", 32'(timeout_err), 32'd1);
    set_ack(1'b1);
    wait_req(1'b0, "to_req_fall");
    set_ack(1'b0);
    wait_idle();
    exp_tx += 1;
    chk("tx_after_to", 32'(tx_count), 32'(exp_tx));
    chk("to_still_set", 32'(timeout_err), 32'd1);

    // Asynchronous reset in REQ_HI with ack high
    push(16'h5A3C);
    s_valid = 1'b0;
    wait_req(1'b1, "rst_req_rise");
    set_ack(1'b1);
    chk("pre_rst_req", 32'(req_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_req_async", 32'(req_o), 32'd0);
    chk("rst_data_async", 32'(data_o), 32'd0);
    chk("rst_tx_async", 32'(tx_count), 32'd0);
    chk("rst_err_clear", 32'(timeout_err), 32'd0);
    exp_tx = 0;
    @(negedge clk);
    rst = 1'b0;
    push(16'h0F0F);
    s_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_req_ack_high", 32'(req_o), 32'd0);
    chk("hold_data_ack_high", 32'(data_o), 32'd0);
    set_ack(1'b0);
    @(negedge clk);
    @(negedge clk);
    chk("hold_until_ack_synced", 32'(data_o), 32'd0);
    auto_ack = 1'b1;
    wait_idle();
    exp_tx = 1;
    chk("tx_after_rst", 32'(tx_count), 32'(exp_tx));

    // tx_count wrap from FFFF
    @(negedge clk);
    force dut.tx_cnt_r = 16'hFFFF;
    @(negedge clk);
    release dut.tx_cnt_r;
    @(negedge clk);
    chk("preload", 32'(tx_count), 32'h0000FFFF);
    push(16'hC3C3);
    s_valid = 1'b0;
    wait_idle();
    exp_tx = 0;
    chk("tx_wrap", 32'(tx_count), 32'(exp_tx));
    chk("wrap_err", 32'(timeout_err), 32'd0);
    chk("wrap_busy", 32'(busy), 32'd0);
    chk("wrap_ready", 32'(s_ready), 32'd1);

    // Data extremes
    push(16'h0000);
    push(16'hFFFF);
    s_valid = 1'b0;
    wait_idle();
    exp_tx += 2;
    chk("tx_extremes", 32'(tx_count), 32'(exp_tx));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
